// File: rtl/spi_peripheral.sv
// Write-side SPI register block: mode-0 16-bit frames -> five 8-bit control registers.
// Define SPI_READBACK_EN to return register contents on cipo during read frames.
module spi_peripheral #(
    parameter int NUM_REGS    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       ncs,
    input  logic       copi,
    output logic       cipo,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle
);

    localparam int NR = (NUM_REGS > 5) ? NUM_REGS : 5;
    localparam logic [7:0] NUM_REGS_L = 8'(NUM_REGS);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        SHIFT,
        COMMIT
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sclk_sync, ncs_sync, copi_sync;
    logic sclk_d, ncs_d;
    logic sclk_s, ncs_s, copi_s;
    logic sclk_rise, ncs_fall, ncs_rise;

    logic [15:0] sr, sr_nxt;
    logic [4:0]  cnt, cnt_nxt;
    logic [6:0]  addr;
    logic        clr, shift_en, commit_chk, wr_ok;
    logic [7:0]  regs [NR];

    // ncs resets low so a frame already in progress at reset release
    // never produces a falling edge and is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            ncs_sync  <= '0;
            copi_sync <= '0;
            sclk_d    <= 1'b0;
            ncs_d     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
            sclk_d    <= sclk_s;
            ncs_d     <= ncs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync[SYNC_STAGES-1];
    assign copi_s    = copi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign ncs_fall  = ~ncs_s & ncs_d;
    assign ncs_rise  = ncs_s & ~ncs_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        clr        = 1'b0;
        shift_en   = 1'b0;
        commit_chk = 1'b0;
        unique case (state)
            IDLE: begin
                if (ncs_fall) begin
                    state_nxt = ARMED;
                    clr       = 1'b1;
                end
            end
            ARMED, SHIFT: begin
                shift_en = sclk_rise;
                if (ncs_rise) begin
                    commit_chk = 1'b1;
                    state_nxt  = COMMIT;
                end else begin
                    state_nxt = SHIFT;
                end
            end
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A final sclk rise coincident with ncs rise is shifted before commit.
    always_comb begin
        sr_nxt  = sr;
        cnt_nxt = cnt;
        if (shift_en) begin
            sr_nxt = {sr[14:0], copi_s};
            if (cnt != 5'd17) cnt_nxt = cnt + 5'd1;
        end
    end

    assign addr  = sr_nxt[14:8];
    assign wr_ok = commit_chk && (cnt_nxt == 5'd16) && sr_nxt[15]
                   && ({1'b0, addr} < NUM_REGS_L);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr  <= '0;
            cnt <= '0;
        end else if (clr) begin
            sr  <= '0;
            cnt <= '0;
        end else begin
            sr  <= sr_nxt;
            cnt <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NR; i++) regs[i] <= 8'h00;
        end else begin
            for (int i = 0; i < NR; i++) begin
                if (wr_ok && addr == 7'(i)) regs[i] <= sr_nxt[7:0];
            end
        end
    end

    assign en_reg_out_7_0  = regs[0];
    assign en_reg_out_15_8 = regs[1];
    assign en_reg_pwm_7_0  = regs[2];
    assign en_reg_pwm_15_8 = regs[3];
    assign pwm_duty_cycle  = regs[4];

`ifdef SPI_READBACK_EN
    logic       sclk_fall, active, load, tx_act, cipo_q;
    logic [7:0] tx, rd_val;

    assign sclk_fall = ~sclk_s & sclk_d;
    assign active    = (state == ARMED) || (state == SHIFT);
    // Load on the 8th rise of a read frame, when the address is complete.
    assign load      = shift_en && (cnt_nxt == 5'd8) && !sr_nxt[7];

    always_comb begin
        rd_val = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (sr_nxt[6:0] == 7'(i)) rd_val = regs[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx     <= 8'h00;
            tx_act <= 1'b0;
            cipo_q <= 1'b0;
        end else if (!active || ncs_rise) begin
            tx     <= 8'h00;
            tx_act <= 1'b0;
            cipo_q <= 1'b0;
        end else if (load) begin
            tx     <= rd_val;
            tx_act <= 1'b1;
        end else if (sclk_fall && tx_act) begin
            cipo_q <= tx[7];
            tx     <= {tx[6:0], 1'b0};
        end
    end

    assign cipo = cipo_q;
`else
    assign cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_peripheral.sv
// Self-checking bench for spi_peripheral: directed plan plus random frames
// against a frame-level register model.
module tb_spi_peripheral;

    logic       clk = 1'b0;
    logic       rst_n, sclk, ncs, copi;
    logic       cipo;
    logic [7:0] r0, r1, r2, r3, r4;

    int checks = 0;
    int errors = 0;

    logic [7:0] m [5];

    spi_peripheral dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sclk            (sclk),
        .ncs             (ncs),
        .copi            (copi),
        .cipo            (cipo),
        .en_reg_out_7_0  (r0),
        .en_reg_out_15_8 (r1),
        .en_reg_pwm_7_0  (r2),
        .en_reg_pwm_15_8 (r3),
        .pwm_duty_cycle  (r4)
    );

    always #5 clk = ~clk;

`ifdef SPI_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    task automatic chk(input string tag, input logic [39:0] obs,
                       input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] model_pack();
        return {m[4], m[3], m[2], m[1], m[0]};
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One bit: sclk low with new data, sample cipo, then rise.
    task automatic spi_bit(input logic b, input logic ec, input string tag,
                           input bit simul_end);
        sclk = 1'b0;
        copi = b;
        wait_clk(5);
        chk(tag, {39'b0, cipo}, {39'b0, ec});
        sclk = 1'b1;
        if (simul_end) ncs = 1'b1;
        else wait_clk(5);
    endtask

    task automatic check_regs(input string tag);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk(tag, {r4, r3, r2, r1, r0}, model_pack());
    endtask

    task automatic send(input logic [15:0] w, input int n, input bit simul,
                        input string tag);
        logic [7:0] rd;
        logic       b, ec;
        int         k;
        rd = (w[14:8] < 7'd5) ? m[w[10:8]] : 8'h00;
        ncs = 1'b0;
        wait_clk(5);
        for (k = 0; k < n; k++) begin
            b  = (k < 16) ? w[15-k] : 1'($urandom_range(0, 1));
            ec = 1'b0;
            if (RB && !w[15] && k >= 8 && k <= 15) ec = rd[15-k];
            spi_bit(b, ec, "cipo", simul && (k == n - 1));
        end
        if (!simul) begin
            sclk = 1'b0;
            wait_clk(5);
            ncs = 1'b1;
        end
        if (n == 16 && w[15] && w[14:8] < 7'd5) m[w[10:8]] = w[7:0];
        check_regs(tag);
        sclk = 1'b0;
        wait_clk(5);
        chk("cipo_idle", {39'b0, cipo}, 40'b0);
    endtask

    initial begin
        logic [15:0] w;
        int          n;
        rst_n = 1'b0;
        sclk  = 1'b0;
        ncs   = 1'b1;
        copi  = 1'b0;
        for (int i = 0; i < 5; i++) m[i] = 8'h00;
        wait_clk(3);
        chk("reset_regs", {r4, r3, r2, r1, r0}, 40'b0);
        chk("reset_cipo", {39'b0, cipo}, 40'b0);
        rst_n = 1'b1;
        wait_clk(5);

        send(16'h8055, 16, 1'b0, "wr_addr0");
        chk("r0_55", {32'b0, r0}, 40'h55);
        send(16'h84A5, 16, 1'b0, "wr_addr4");
        chk("r4_a5", {32'b0, r4}, 40'hA5);
        send(16'h8512, 16, 1'b0, "wr_addr5");
        send(16'h0077, 16, 1'b0, "rd_0077");
        send(16'h823C, 16, 1'b0, "wr_addr2");
        send(16'h0200, 16, 1'b0, "rd_addr2");
        send(16'h81FF, 15, 1'b0, "short15");
        send(16'h81FF, 17, 1'b0, "long17");
        chk("r1_zero", {32'b0, r1}, 40'h00);
        send(16'h8233, 16, 1'b1, "simul_end");
        chk("r2_33", {32'b0, r2}, 40'h33);

        // Reset mid-frame, released with ncs still low.
        w = 16'h83F0;
        ncs = 1'b0;
        wait_clk(5);
        for (int k = 0; k < 8; k++) spi_bit(w[15-k], 1'b0, "cipo_pre", 1'b0);
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) m[i] = 8'h00;
        wait_clk(2);
        chk("midrst_regs", {r4, r3, r2, r1, r0}, 40'b0);
        chk("midrst_cipo", {39'b0, cipo}, 40'b0);
        rst_n = 1'b1;
        for (int k = 8; k < 16; k++) spi_bit(w[15-k], 1'b0, "cipo_post", 1'b0);
        sclk = 1'b0;
        wait_clk(5);
        ncs = 1'b1;
        check_regs("after_midrst");
        chk("r3_zero", {32'b0, r3}, 40'h00);
        wait_clk(5);
        send(16'h83F0, 16, 1'b0, "clean_83f0");
        chk("r3_f0", {32'b0, r3}, 40'hF0);

        // sclk activity with ncs high is ignored.
        copi = 1'b1;
        for (int k = 0; k < 16; k++) begin
            sclk = 1'b1;
            wait_clk(5);
            sclk = 1'b0;
            wait_clk(5);
            chk("ncs_hi_cipo", {39'b0, cipo}, 40'b0);
        end
        check_regs("ncs_hi_regs");

        // Random frames, lengths and addresses.
        for (int t = 0; t < 30; t++) begin
            w = 16'($urandom);
            w[14:8] = 7'($urandom_range(0, 6));
            case ($urandom_range(0, 5))
                0:       n = 15;
                1:       n = 17;
                default: n = 16;
            endcase
            send(w, n, 1'($urandom_range(0, 1)), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/spi_peripheral.md
# spi_peripheral

Write-side SPI register block feeding the PWM peripheral in the onboarding design. It receives 16-bit SPI mode-0 frames on three pins sampled in the system clock domain, and decodes them into five 8-bit control registers. Those registers drive the PWM peripheral's output-enable, PWM-enable and duty-cycle inputs, and sit beside it inside the top-level wrapper.

## Interface
Parameters:
- `NUM_REGS`, 5: number of implemented registers, at addresses 0x00 to NUM_REGS-1.
- `SYNC_STAGES`, 2: synchronizer flops per SPI input.

Ports:
- `clk`  input  1  system clock; one clock, all state in this domain.
- `rst_n`  input  1  reset; asynchronous assert, active-low.
- `sclk`  input  1  SPI clock, asynchronous to `clk`.
- `ncs`  input  1  SPI chip select, active-low, asynchronous.
- `copi`  input  1  SPI data in, asynchronous.
- `cipo`  output  1  SPI data out; meaningful only with readback (see Configuration).
- `en_reg_out_7_0`  output  8  address 0x00.
- `en_reg_out_15_8`  output  8  address 0x01.
- `en_reg_pwm_7_0`  output  8  address 0x02.
- `en_reg_pwm_15_8`  output  8  address 0x03.
- `pwm_duty_cycle`  output  8  address 0x04.

## Operation
- Inputs: `sclk`, `ncs` and `copi` each pass through SYNC_STAGES flops. Edge detect compares the last synchronized stage with one extra history flop.
- Frame layout, MSB first: bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
- SPI mode 0. `copi` is sampled on each synchronized `sclk` rising edge while `ncs` is low.
- States:
  - IDLE: entered from reset. No bits are accepted.
  - ARMED: entered on `ncs` falling edge. Shift register and 5-bit bit counter are cleared.
  - SHIFT: active while `ncs` is low. Each `sclk` rise shifts one bit in. The counter saturates at 17.
  - COMMIT: one cycle, on `ncs` rising edge. Returns to IDLE.
- Commit condition: counter == 16, bit15 == 1, and address < NUM_REGS. When met, data is written to the addressed register. Otherwise the frame is discarded with no register change.
- Frames with fewer or more than 16 bits are discarded.
- `sclk` edges while `ncs` is high are ignored.
- If reset is released while `ncs` is low, that frame is ignored. The block waits in IDLE for a fresh `ncs` falling edge.
- Read frames (bit15 == 0) never modify registers.
- `cipo` is 0 unless readback is compiled in.

## Timing
- Reset values: all five registers are 0x00 and `cipo` is 0. Asserting reset mid-frame clears the counter and shift register immediately.
- Commit latency: a register updates on the 3rd `clk` rising edge after the `ncs` pin rises (SYNC_STAGES + 1), with up to +1 cycle of synchronizer uncertainty.
- Between frames, registers hold their value with no glitches.
- SPI constraints:
  - `sclk` high and low times must each be at least 3 `clk` periods.
  - `ncs` must be high for at least 3 `clk` periods between frames.
  - `copi` must be stable for at least 3 `clk` periods around each `sclk` rise.
- Simultaneous events: if `ncs` rises in the same synchronized cycle as a final `sclk` rise, that bit counts. The shift happens first, then the commit evaluates the updated counter.

## Configuration
Macro: `SPI_READBACK_EN`.
- Defined: read frames return data on `cipo`.
  - On the 8th `sclk` rise, the addressed register value is loaded into an 8-bit TX shift register. Unimplemented addresses load 0x00.
  - `cipo` presents TX bit7 from the next synchronized `sclk` falling edge, then shifts once per subsequent falling edge (mode 0).
  - `cipo` returns to 0 when `ncs` goes high.
- Undefined: `cipo` is tied to 0, and no TX logic is synthesized. Register write behaviour is identical in both builds.

## Test plan
- Reset, then write frame 0x8055 (addr 0x00, data 0x55) -> `en_reg_out_7_0` = 0x55 within 4 `clk` cycles of `ncs` rise; the other registers stay 0x00.
- Write 0x84A5 -> `pwm_duty_cycle` = 0xA5. Write 0x8512 (addr 0x05) -> no register changes.
- Read frame 0x0077 -> no registers change. With `SPI_READBACK_EN` and `en_reg_pwm_7_0` = 0x3C, read 0x0200 -> `cipo` shifts 0,0,1,1,1,1,0,0 over the last 8 bits.
- 15-bit frame, then 17-bit frame, each targeting 0x01 with 0xFF -> `en_reg_out_15_8` remains 0x00.
- Assert `rst_n` after 8 bits of write 0x83F0, release it with `ncs` still low, finish the frame -> `en_reg_pwm_15_8` = 0x00. A following clean frame 0x83F0 -> 0xF0.
- Toggle `sclk` 16 times with `ncs` high, `copi` = 1 -> no register changes and `cipo` = 0.
